// File: rtl/gray2bin_ptr_receiver.sv
// gray2bin_ptr_receiver
// Destination-clock side of a Gray-coded pointer crossing. The pointer passes
// through a SYNC_STAGES-deep synchronizer and is decoded back to binary. Each
// new value is published with a one-cycle valid pulse.
// Optional feature macro: GRAY_STEP_CHECK_EN. When it is defined, any update
// that is not a single +1 step (mod 2^W) sets the sticky step_err_o flag.
// When it is undefined, step_err_o is tied low and err_clr_i is ignored.
module gray2bin_ptr_receiver #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gray_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] bin_o,
  output logic                  bin_vld_o,
  output logic                  step_err_o
);

  localparam int CNT_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES - 1);

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  base_q, base_d;
  logic [DATA_WIDTH-1:0] bin_d;
  logic                  vld_d;
  logic                  step_bad;

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] gsync;
  logic [DATA_WIDTH-1:0] dec;
  logic [DATA_WIDTH-1:0] bin_inc;

  // Synchronizer chain: the asynchronous pointer ripples through SYNC_STAGES flops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign gsync   = sync_q[SYNC_STAGES-1];
  assign bin_inc = bin_o + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at and above it
  always_comb begin
    dec = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      dec[i] = ^(gsync >> i);
    end
  end

  // Next-state logic: FILL waits for the chain to hold real samples, then the
  // first TRACK cycle loads an unchecked baseline before normal tracking
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    bin_d    = bin_o;
    vld_d    = 1'b0;
    step_bad = 1'b0;
    case (state_q)
      FILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = TRACK;
          base_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TRACK: begin
        if (base_q) begin
          bin_d  = dec;
          vld_d  = 1'b1;
          base_d = 1'b0;
        end else if (dec != bin_o) begin
          bin_d    = dec;
          vld_d    = 1'b1;
          step_bad = (dec != bin_inc);
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
        base_d  = 1'b0;
      end
    endcase
  end

  // State, fill counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      base_q    <= 1'b0;
      bin_o     <= '0;
      bin_vld_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      bin_o     <= bin_d;
      bin_vld_o <= vld_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic err_q;

  // Sticky step error: a new illegal step wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (step_bad) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign step_err_o = err_q;
`else
  logic unused_step;
  assign unused_step = err_clr_i ^ step_bad;
  assign step_err_o  = 1'b0;
`endif

endmodule
